// File: rtl/comparator_pipe.sv
// Two-stage valid/ready compare pipeline: S1 captures operands, S2 holds the 1-bit result.
// Accept-to-consume latency is 2 edges; holds two beats under stall, then drops in_ready.
module comparator_pipe #(
  parameter int N     = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       sel,
  input  logic             is_signed,
  input  logic [N-1:0]     value1,
  input  logic [N-1:0]     value2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] hit_cnt
);

  localparam logic [2:0] OP_ZERO = 3'b000;
  localparam logic [2:0] OP_ONE  = 3'b001;
  localparam logic [2:0] OP_EQ   = 3'b010;
  localparam logic [2:0] OP_NE   = 3'b011;
  localparam logic [2:0] OP_GE   = 3'b100;
  localparam logic [2:0] OP_LE   = 3'b101;
  localparam logic [2:0] OP_LT   = 3'b110;
  localparam logic [2:0] OP_GT   = 3'b111;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic           s1_vld;
  logic [N-1:0]   s1_a;
  logic [N-1:0]   s1_b;
  logic [2:0]     s1_sel;
  logic           s1_sgn;

  logic           s2_vld;
  logic           s2_res;

  logic           s2_load;
  logic           s1_load;
  logic           consume;

  logic [N-1:0]   key_a;
  logic [N-1:0]   key_b;
  logic           a_eq_b;
  logic           a_lt_b;
  logic           res_next;

  assign consume = s2_vld && out_ready;
  assign s2_load = !s2_vld || out_ready;
  // S1 is free when empty, or when its occupant advances into S2 this edge
  assign s1_load = !s1_vld || s2_load;
  assign in_ready = rst_n && s1_load;

  assign out_valid = s2_vld;
  assign out       = s2_res;

  // Flipping the sign bit maps two's-complement order onto unsigned order
  assign key_a  = {s1_a[N-1] ^ s1_sgn, s1_a[N-2:0]};
  assign key_b  = {s1_b[N-1] ^ s1_sgn, s1_b[N-2:0]};
  assign a_eq_b = (s1_a == s1_b);
  assign a_lt_b = (key_a < key_b);

  always_comb begin
    res_next = 1'b0;
    case (s1_sel)
      OP_ZERO: res_next = 1'b0;
      OP_ONE:  res_next = 1'b1;
      OP_EQ:   res_next = a_eq_b;
      OP_NE:   res_next = !a_eq_b;
      OP_GE:   res_next = !a_lt_b;
      OP_LE:   res_next = a_lt_b || a_eq_b;
      OP_LT:   res_next = a_lt_b;
      OP_GT:   res_next = !a_lt_b && !a_eq_b;
      default: res_next = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_vld <= 1'b0;
      s1_a   <= '0;
      s1_b   <= '0;
      s1_sel <= '0;
      s1_sgn <= 1'b0;
    end else if (s1_load) begin
      s1_vld <= in_valid;
      if (in_valid) begin
        s1_a   <= value1;
        s1_b   <= value2;
        s1_sel <= sel;
        s1_sgn <= is_signed;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_vld <= 1'b0;
      s2_res <= 1'b0;
    end else if (s2_load) begin
      s2_vld <= s1_vld;
      s2_res <= s1_vld ? res_next : 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_cnt <= '0;
    end else if (cnt_clr) begin
      hit_cnt <= '0;
    end else if (consume && s2_res && (hit_cnt != CNT_MAX)) begin
      hit_cnt <= hit_cnt + CNT_ONE;
    end
  end

endmodule
